pipe_addr_ctrl: RTL and testbench

//  Address/count generator for the ADC sample pipeline RAM (circular buffer).

---
 rtl/pipe_addr_ctrl.sv | 91 +++++++++
 tb/tb_pipe_addr_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_addr_ctrl.sv
// Address/occupancy generator for the ADC sample pipeline circular buffer.
// Tracks write count, RAM addresses, occupancy, lock and slip status.
module pipe_addr_ctrl #(
    parameter int AW = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PIP_RST,
    input  logic          WE,
    input  logic          RE,
    input  logic [8:0]    PDEPTH,
    output logic [8:0]    WCNT,
    output logic [AW-1:0] WADDR,
    output logic [AW-1:0] RADDR,
    output logic [AW:0]   OCC,
    output logic          LOCKED,
    output logic          SLIP,
    output logic          DEPTH_CHG
);

    localparam logic [AW:0] OCC_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [8:0]  WCNT_MAX = 9'h1FF;

    logic [8:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          locked_q, locked_d;
    logic          slip_q, slip_d;
    logic          dchg_q, dchg_d;
    logic [8:0]    pdepth_q;

    logic wr_only, rd_only, under, over;

    always_comb begin
        wr_only = WE & ~RE;
        rd_only = RE & ~WE;
        under   = rd_only & (occ_q == '0);
        over    = wr_only & (occ_q == OCC_FULL);

        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        wcnt_d   = wcnt_q;
        occ_d    = occ_q;
        locked_d = locked_q | RE;
        // Imbalance only counts once running; under/overflow always do.
        slip_d   = slip_q | under | over | (locked_q & (WE ^ RE));
        dchg_d   = dchg_q | (locked_q & (PDEPTH != pdepth_q));

        if (WE && !over)
            waddr_d = waddr_q + 1'b1;
        if (RE && !under)
            raddr_d = raddr_q + 1'b1;
        if (WE && wcnt_q != WCNT_MAX)
            wcnt_d = wcnt_q + 1'b1;
        if (wr_only && !over)
            occ_d = occ_q + 1'b1;
        else if (rd_only && !under)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST || PIP_RST) begin
            wcnt_q   <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            occ_q    <= '0;
            locked_q <= 1'b0;
            slip_q   <= 1'b0;
            dchg_q   <= 1'b0;
            pdepth_q <= RST ? 9'd0 : PDEPTH;
        end else begin
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            occ_q    <= occ_d;
            locked_q <= locked_d;
            slip_q   <= slip_d;
            dchg_q   <= dchg_d;
        end
    end

    assign WCNT      = wcnt_q;
    assign WADDR     = waddr_q;
    assign RADDR     = raddr_q;
    assign OCC       = occ_q;
    assign LOCKED    = locked_q;
    assign SLIP      = slip_q;
    assign DEPTH_CHG = dchg_q;

endmodule

// File: tb/tb_pipe_addr_ctrl.sv
// Directed self-checking bench for pipe_addr_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled then.
module tb_pipe_addr_ctrl;

    logic       CLK, RST, PIP_RST, WE, RE;
    logic [8:0] PDEPTH;
    logic [8:0] WCNT;
    logic [8:0] WADDR, RADDR;
    logic [9:0] OCC;
    logic       LOCKED, SLIP, DEPTH_CHG;

    int npass = 0;
    int ntotal = 0;

    pipe_addr_ctrl #(.AW(9)) dut (
        .CLK(CLK), .RST(RST), .PIP_RST(PIP_RST), .WE(WE), .RE(RE),
        .PDEPTH(PDEPTH), .WCNT(WCNT), .WADDR(WADDR), .RADDR(RADDR),
        .OCC(OCC), .LOCKED(LOCKED), .SLIP(SLIP), .DEPTH_CHG(DEPTH_CHG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; PIP_RST = 1'b0; WE = 1'b0; RE = 1'b0; PDEPTH = 9'd0;
        step(2);
        ntotal++; if (WCNT !== 9'd0) $display("FAIL rst0_wcnt got %0d exp 0", WCNT); else npass++;
        ntotal++; if (OCC !== 10'd0) $display("FAIL rst0_occ got %0d exp 0", OCC); else npass++;
        ntotal++; if ({LOCKED, SLIP, DEPTH_CHG} !== 3'b000) $display("FAIL rst0_flags got %b exp 000", {LOCKED, SLIP, DEPTH_CHG}); else npass++;
        RST = 1'b0; WE = 1'b1;
        step(4);
        WE = 1'b0; RE = 1'b1;
        step(2);
        ntotal++; if (OCC !== 10'd2) $display("FAIL act_occ got %0d exp 2", OCC); else npass++;
        ntotal++; if ({LOCKED, SLIP} !== 2'b11) $display("FAIL act_flags got %b exp 11", {LOCKED, SLIP}); else npass++;
        RST = 1'b1; WE = 1'b1;
        step(1);
        RST = 1'b0; WE = 1'b0; RE = 1'b0;
        ntotal++; if (WCNT !== 9'd0) $display("FAIL rst1_wcnt got %0d exp 0", WCNT); else npass++;
        ntotal++; if (WADDR !== 9'd0) $display("FAIL rst1_waddr got %0d exp 0", WADDR); else npass++;
        ntotal++; if (RADDR !== 9'd0) $display("FAIL rst1_raddr got %0d exp 0", RADDR); else npass++;
        ntotal++; if (OCC !== 10'd0) $display("FAIL rst1_occ got %0d exp 0", OCC); else npass++;
        ntotal++; if ({LOCKED, SLIP, DEPTH_CHG} !== 3'b000) $display("FAIL rst1_flags got %b exp 000", {LOCKED, SLIP, DEPTH_CHG}); else npass++;
    endtask

    task automatic test_fill_run;
        PDEPTH = 9'd20; PIP_RST = 1'b1; WE = 1'b1; RE = 1'b1;
        step(1);
        ntotal++; if (WCNT !== 9'd0 || OCC !== 10'd0) $display("FAIL piprst_wins got wcnt %0d occ %0d exp 0 0", WCNT, OCC); else npass++;
        PIP_RST = 1'b0; RE = 1'b0;
        step(21);
        ntotal++; if (WCNT !== 9'd21) $display("FAIL fill_wcnt got %0d exp 21", WCNT); else npass++;
        ntotal++; if (WADDR !== 9'd21) $display("FAIL fill_waddr got %0d exp 21", WADDR); else npass++;
        ntotal++; if (OCC !== 10'd21) $display("FAIL fill_occ got %0d exp 21", OCC); else npass++;
        ntotal++; if (RADDR !== 9'd0 || LOCKED !== 1'b0) $display("FAIL fill_rd got raddr %0d lock %b exp 0 0", RADDR, LOCKED); else npass++;
        RE = 1'b1;
        step(600);
        ntotal++; if (OCC !== 10'd21) $display("FAIL run_occ got %0d exp 21", OCC); else npass++;
        ntotal++; if (WADDR !== 9'd109) $display("FAIL run_waddr got %0d exp 109", WADDR); else npass++;
        ntotal++; if (RADDR !== 9'd88) $display("FAIL run_raddr got %0d exp 88", RADDR); else npass++;
        ntotal++; if (WCNT !== 9'd511) $display("FAIL run_wcnt got %0d exp 511", WCNT); else npass++;
        ntotal++; if ({LOCKED, SLIP, DEPTH_CHG} !== 3'b100) $display("FAIL run_flags got %b exp 100", {LOCKED, SLIP, DEPTH_CHG}); else npass++;
    endtask

    task automatic test_depth_chg;
        PDEPTH = 9'd30;
        step(1);
        ntotal++; if ({DEPTH_CHG, SLIP} !== 2'b10) $display("FAIL dchg_set got %b exp 10", {DEPTH_CHG, SLIP}); else npass++;
        PIP_RST = 1'b1; WE = 1'b0; RE = 1'b0;
        step(1);
        PIP_RST = 1'b0;
        ntotal++; if (DEPTH_CHG !== 1'b0) $display("FAIL dchg_clr got %b exp 0", DEPTH_CHG); else npass++;
        WE = 1'b1;
        step(1);
        RE = 1'b1;
        step(3);
        ntotal++; if ({LOCKED, DEPTH_CHG} !== 2'b10) $display("FAIL dchg_recap got %b exp 10", {LOCKED, DEPTH_CHG}); else npass++;
        PDEPTH = 9'd20;
        step(1);
        ntotal++; if (DEPTH_CHG !== 1'b1) $display("FAIL dchg_vs30 got %b exp 1", DEPTH_CHG); else npass++;
    endtask

    task automatic test_slip;
        PIP_RST = 1'b1; WE = 1'b0; RE = 1'b0;
        step(1);
        PIP_RST = 1'b0; WE = 1'b1;
        step(3);
        RE = 1'b1;
        step(4);
        ntotal++; if (OCC !== 10'd3 || SLIP !== 1'b0) $display("FAIL slip_pre got occ %0d slip %b exp 3 0", OCC, SLIP); else npass++;
        WE = 1'b0;
        step(1);
        ntotal++; if (OCC !== 10'd2 || SLIP !== 1'b1) $display("FAIL slip_drop got occ %0d slip %b exp 2 1", OCC, SLIP); else npass++;
        WE = 1'b1;
        step(3);
        ntotal++; if (OCC !== 10'd2 || SLIP !== 1'b1) $display("FAIL slip_sticky got occ %0d slip %b exp 2 1", OCC, SLIP); else npass++;
        PIP_RST = 1'b1;
        step(1);
        PIP_RST = 1'b0; WE = 1'b0; RE = 1'b0;
        ntotal++; if (SLIP !== 1'b0) $display("FAIL slip_clr got %b exp 0", SLIP); else npass++;
    endtask

    task automatic test_underflow;
        RE = 1'b1;
        step(1);
        RE = 1'b0;
        ntotal++; if (RADDR !== 9'd0 || OCC !== 10'd0) $display("FAIL uf_hold got raddr %0d occ %0d exp 0 0", RADDR, OCC); else npass++;
        ntotal++; if ({LOCKED, SLIP} !== 2'b11) $display("FAIL uf_flags got %b exp 11", {LOCKED, SLIP}); else npass++;
    endtask

    task automatic test_overflow;
        PIP_RST = 1'b1;
        step(1);
        PIP_RST = 1'b0; WE = 1'b1;
        step(511);
        ntotal++; if (OCC !== 10'd511 || WADDR !== 9'd511) $display("FAIL of_511 got occ %0d waddr %0d exp 511 511", OCC, WADDR); else npass++;
        ntotal++; if (WCNT !== 9'd511 || SLIP !== 1'b0) $display("FAIL of_511w got wcnt %0d slip %b exp 511 0", WCNT, SLIP); else npass++;
        step(1);
        ntotal++; if (OCC !== 10'd512 || WADDR !== 9'd0 || SLIP !== 1'b0) $display("FAIL of_full got occ %0d waddr %0d slip %b exp 512 0 0", OCC, WADDR, SLIP); else npass++;
        step(88);
        WE = 1'b0;
        ntotal++; if (OCC !== 10'd512 || WADDR !== 9'd0) $display("FAIL of_hold got occ %0d waddr %0d exp 512 0", OCC, WADDR); else npass++;
        ntotal++; if (WCNT !== 9'd511) $display("FAIL of_wcnt got %0d exp 511", WCNT); else npass++;
        ntotal++; if ({LOCKED, SLIP} !== 2'b01) $display("FAIL of_flags got %b exp 01", {LOCKED, SLIP}); else npass++;
    endtask

    task automatic test_back_to_back;
        RST = 1'b1; PIP_RST = 1'b1; PDEPTH = 9'd7;
        step(1);
        RST = 1'b0; PIP_RST = 1'b0; WE = 1'b1; RE = 1'b1;
        step(1);
        ntotal++; if ({LOCKED, DEPTH_CHG} !== 2'b10) $display("FAIL b2b_lock got %b exp 10", {LOCKED, DEPTH_CHG}); else npass++;
        ntotal++; if (WADDR !== 9'd1 || RADDR !== 9'd1 || OCC !== 10'd0) $display("FAIL b2b_addr got w %0d r %0d occ %0d exp 1 1 0", WADDR, RADDR, OCC); else npass++;
        step(1);
        WE = 1'b0; RE = 1'b0;
        ntotal++; if ({DEPTH_CHG, SLIP} !== 2'b10) $display("FAIL b2b_rstcap got %b exp 10", {DEPTH_CHG, SLIP}); else npass++;
    endtask

    initial begin
        test_reset;
        test_fill_run;
        test_depth_chg;
        test_slip;
        test_underflow;
        test_overflow;
        test_back_to_back;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
